// File: rtl/traffic_countdown_display_pkg.sv
// Shared types and constants for the traffic countdown display: lamp codes,
// phase durations, 7-segment patterns and the per-road counter step function.
package traffic_pkg;

    typedef logic [2:0] lamp_t;

    localparam lamp_t LAMP_G = 3'b100;
    localparam lamp_t LAMP_Y = 3'b010;
    localparam lamp_t LAMP_R = 3'b001;

    localparam logic [4:0] MAIN_G_DUR = 5'd15;
    localparam logic [4:0] MAIN_Y_DUR = 5'd3;
    localparam logic [4:0] MAIN_R_DUR = 5'd10;
    localparam logic [4:0] AUX_G_DUR  = 5'd7;
    localparam logic [4:0] AUX_Y_DUR  = 5'd3;
    localparam logic [4:0] AUX_R_DUR  = 5'd18;

    // Segment order {a,b,c,d,e,f,g}, active-high; index = digit value.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'b1111011, 7'b1111111, 7'b1110000, 7'b1011111, 7'b1011011,
        7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    localparam logic [3:0] CODE_BLANK = 4'd10;
    localparam logic [3:0] CODE_DASH  = 4'd11;

    typedef struct packed {
        logic [4:0] cnt;
        logic       fault;
    } road_next_t;

    function automatic logic lamp_valid(input lamp_t lamp);
        return (lamp == LAMP_G) || (lamp == LAMP_Y) || (lamp == LAMP_R);
    endfunction

    // One road's next count: a phase change reloads even if a tick coincides.
    function automatic road_next_t road_step(
        input lamp_t      prev,
        input lamp_t      lamp,
        input logic [4:0] cnt,
        input logic       tick,
        input logic [4:0] dur_g,
        input logic [4:0] dur_y,
        input logic [4:0] dur_r
    );
        road_next_t r;
        r.cnt   = cnt;
        r.fault = 1'b0;
        if (!lamp_valid(lamp)) begin
            r.cnt   = 5'd0;
            r.fault = 1'b1;
        end else if (lamp != prev) begin
            r.cnt = (lamp == LAMP_G) ? dur_g : (lamp == LAMP_Y) ? dur_y : dur_r;
        end else if (tick) begin
            if (cnt > 5'd1)
                r.cnt = cnt - 5'd1;
            else if (cnt == 5'd1)
                r.fault = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/traffic_countdown_display_if.sv
// Lamp/tick inputs and countdown/display outputs of the countdown display.
interface traffic_countdown_display_if;
    logic       sec_tick;
    logic [2:0] light_main;
    logic [2:0] light_auxiliary;
    logic [4:0] cnt_main;
    logic [4:0] cnt_aux;
    logic [6:0] seg;
    logic [3:0] an;
    logic       err;

    modport master (output sec_tick, light_main, light_auxiliary,
                    input  cnt_main, cnt_aux, seg, an, err);
    modport slave  (input  sec_tick, light_main, light_auxiliary,
                    output cnt_main, cnt_aux, seg, an, err);
endinterface

// File: rtl/traffic_countdown_display_seg7.sv
// Combinational 7-segment decoder: 0-9 digits, 10 blank, 11 dash.
module seg7_decoder
    import traffic_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9: seg = SEG_DIGIT[code];
            CODE_DASH:                    seg = SEG_DASH;
            default:                      seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/traffic_countdown_display.sv
// Per-road countdown tracking of the traffic controller plus a 4-digit
// multiplexed 7-segment display of both counts.
module traffic_countdown_display
    import traffic_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd50000
) (
    input  logic                          clk,
    input  logic                          RST,
    traffic_countdown_display_if.slave    bus
);
    localparam logic [15:0] DIV_LAST = SCAN_DIV - 16'd1;

    lamp_t       prev_main, prev_aux;
    logic [4:0]  cnt_main_q, cnt_aux_q;
    logic        err_q;
    logic [15:0] div_q;
    logic [1:0]  idx_q;
    logic [3:0]  an_q;
    logic [6:0]  seg_q;

    road_next_t  nxt_main, nxt_aux;
    logic [4:0]  disp_cnt;
    logic        disp_bad, tens;
    logic [3:0]  units, code;
    logic [6:0]  seg_dec;

    assign nxt_main = road_step(prev_main, bus.light_main, cnt_main_q, bus.sec_tick,
                                MAIN_G_DUR, MAIN_Y_DUR, MAIN_R_DUR);
    assign nxt_aux  = road_step(prev_aux, bus.light_auxiliary, cnt_aux_q, bus.sec_tick,
                                AUX_G_DUR, AUX_Y_DUR, AUX_R_DUR);

    // idx 3/2 show the main road, 1/0 the auxiliary; odd index is the tens digit.
    always_comb begin
        disp_cnt = idx_q[1] ? cnt_main_q : cnt_aux_q;
        disp_bad = idx_q[1] ? !lamp_valid(bus.light_main) : !lamp_valid(bus.light_auxiliary);
        tens     = (disp_cnt >= 5'd10);
        units    = 4'(tens ? disp_cnt - 5'd10 : disp_cnt);
        if (disp_bad)
            code = CODE_DASH;
        else if (idx_q[0])
            code = tens ? 4'd1 : CODE_BLANK;
        else
            code = units;
    end

    seg7_decoder u_dec (
        .code (code),
        .seg  (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (RST) begin
            prev_main  <= LAMP_G;
            prev_aux   <= LAMP_R;
            cnt_main_q <= MAIN_G_DUR;
            cnt_aux_q  <= AUX_R_DUR;
            err_q      <= 1'b0;
            div_q      <= 16'd0;
            idx_q      <= 2'd3;
            an_q       <= 4'b0111;
            seg_q      <= SEG_DIGIT[1];
        end else begin
            prev_main  <= bus.light_main;
            prev_aux   <= bus.light_auxiliary;
            cnt_main_q <= nxt_main.cnt;
            cnt_aux_q  <= nxt_aux.cnt;
            err_q      <= err_q | nxt_main.fault | nxt_aux.fault;
            if (div_q == DIV_LAST) begin
                div_q <= 16'd0;
                idx_q <= idx_q - 2'd1;
            end else begin
                div_q <= div_q + 16'd1;
            end
            // an and seg both register off the same index so they switch together.
            an_q  <= ~(4'b0001 << idx_q);
            seg_q <= seg_dec;
        end
    end

    assign bus.cnt_main = cnt_main_q;
    assign bus.cnt_aux  = cnt_aux_q;
    assign bus.err      = err_q;
    assign bus.an       = an_q;
    assign bus.seg      = seg_q;

endmodule

// File: tb/tb_traffic_countdown_display.sv
// Bench for traffic_countdown_display: vector table, directed display/reset
// sequences and randomized lamp/tick traffic against a reference model.
module tb_traffic_countdown_display;

    localparam int SD = 4;
    localparam logic [2:0] G = 3'b100, Y = 3'b010, R = 3'b001;

    logic clk = 1'b0;
    logic RST;
    always #5 clk = ~clk;

    traffic_countdown_display_if bus();

    traffic_countdown_display #(.SCAN_DIV(16'd4)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model state
    logic [6:0] DIG [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    int         m_cnt [2];
    logic [2:0] m_prev [2];
    bit         m_err;
    int         m_cyc, m_idx;
    logic [3:0] m_an;
    logic [6:0] m_seg;

    function automatic int dur(input int road, input logic [2:0] l);
        case (l)
            3'b100:  return road == 0 ? 15 : 7;
            3'b010:  return 3;
            3'b001:  return road == 0 ? 10 : 18;
            default: return -1;
        endcase
    endfunction

    // One clock edge: advance model with the inputs currently driven, compare after.
    task automatic cycle();
        bit r, t;
        logic [2:0] l [2];
        int road, v, d;
        r = RST; t = bus.sec_tick;
        l[0] = bus.light_main; l[1] = bus.light_auxiliary;
        @(posedge clk);
        if (r) begin
            m_prev[0] = G; m_prev[1] = R; m_cnt[0] = 15; m_cnt[1] = 18;
            m_err = 0; m_cyc = 0; m_idx = 3; m_an = 4'b0111; m_seg = DIG[1];
        end else begin
            road = (m_idx >= 2) ? 0 : 1;
            v = m_cnt[road];
            m_an = 4'b1111; m_an[m_idx] = 1'b0;
            if (dur(road, l[road]) < 0) m_seg = 7'b0000001;
            else if (m_idx % 2 == 1)    m_seg = (v / 10 == 0) ? 7'b0000000 : DIG[v / 10];
            else                        m_seg = DIG[v % 10];
            for (int k = 0; k < 2; k++) begin
                d = dur(k, l[k]);
                if (d < 0) begin m_cnt[k] = 0; m_err = 1; end
                else if (l[k] != m_prev[k]) m_cnt[k] = d;
                else if (t) begin
                    if (m_cnt[k] > 1) m_cnt[k]--;
                    else if (m_cnt[k] == 1) m_err = 1;
                end
                m_prev[k] = l[k];
            end
            m_cyc++;
            if (m_cyc % SD == 0) m_idx = (m_idx + 3) % 4;
        end
        #1;
        chk("model_cnt_main", bus.cnt_main, m_cnt[0]);
        chk("model_cnt_aux",  bus.cnt_aux,  m_cnt[1]);
        chk("model_err",      bus.err,      m_err);
        chk("model_an",       bus.an,       m_an);
        chk("model_seg",      bus.seg,      m_seg);
    endtask

    task automatic drive(input bit r, input bit t, input logic [2:0] lm, input logic [2:0] la);
        RST = r; bus.sec_tick = t; bus.light_main = lm; bus.light_auxiliary = la;
    endtask

    typedef struct {
        bit rst; bit tick; logic [2:0] lm; logic [2:0] la;
        int em; int ea; bit ee;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(input bit rst, input bit tick, input logic [2:0] lm,
                                input logic [2:0] la, input int em, input int ea, input bit ee);
        vec_t v;
        v.rst = rst; v.tick = tick; v.lm = lm; v.la = la; v.em = em; v.ea = ea; v.ee = ee;
        return v;
    endfunction

    logic [3:0] prev_an;
    bit found;
    logic [3:0] exp_an [4]  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [6:0] exp_seg [4] = '{7'b0110000, 7'b1101101, 7'b0000000, 7'b1110000};

    initial begin
        drive(1, 0, G, R);

        tv.push_back(mk(1, 0, G, R, 15, 18, 0));
        for (int i = 1; i <= 14; i++) tv.push_back(mk(0, 1, G, R, 15 - i, 18 - i, 0));
        tv.push_back(mk(0, 1, Y, R, 3, 3, 0));        // load beats tick
        tv.push_back(mk(0, 1, Y, R, 2, 2, 0));
        tv.push_back(mk(0, 1, Y, R, 1, 1, 0));
        tv.push_back(mk(0, 1, Y, R, 1, 1, 1));        // overrun: hold at 1, err
        tv.push_back(mk(0, 0, R, G, 10, 7, 1));       // both reload together
        tv.push_back(mk(0, 1, R, G, 9, 6, 1));
        tv.push_back(mk(0, 0, R, 3'b011, 9, 0, 1));
        tv.push_back(mk(0, 0, R, G, 9, 7, 1));
        tv.push_back(mk(1, 1, R, G, 15, 18, 0));
        tv.push_back(mk(0, 0, G, R, 15, 18, 0));

        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].tick, tv[i].lm, tv[i].la);
            cycle();
            chk("tbl_cnt_main", bus.cnt_main, tv[i].em);
            chk("tbl_cnt_aux",  bus.cnt_aux,  tv[i].ea);
            chk("tbl_err",      bus.err,      tv[i].ee);
        end

        // Scan order with main=12, aux=7
        drive(1, 0, G, R); cycle();
        chk("rst_an", bus.an, 4'b0111);
        chk("rst_seg", bus.seg, 7'b0110000);
        for (int i = 0; i < 3; i++) begin drive(0, 1, G, R); cycle(); end
        drive(0, 0, G, G); cycle();
        chk("scan_setup_main", bus.cnt_main, 12);
        chk("scan_setup_aux", bus.cnt_aux, 7);
        found = 0;
        prev_an = bus.an;
        for (int i = 0; i < 24 && !found; i++) begin
            cycle();
            if (bus.an == 4'b0111 && prev_an != 4'b0111) found = 1;
            prev_an = bus.an;
        end
        chk("scan_sync_found", found, 1);
        for (int k = 0; k < 4; k++) begin
            chk("scan_an", bus.an, exp_an[k]);
            chk("scan_seg", bus.seg, exp_seg[k]);
            for (int j = 0; j < SD; j++) cycle();
        end

        // Invalid aux lamp shows dashes on both aux digits
        drive(0, 0, G, 3'b011); cycle();
        chk("inv_cnt_aux", bus.cnt_aux, 0);
        chk("inv_err", bus.err, 1);
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (bus.an[1:0] != 2'b11) chk("inv_dash", bus.seg, 7'b0000001);
        end
        drive(0, 0, G, G); cycle();
        chk("inv_reload_aux", bus.cnt_aux, 7);

        // Reset overrides a simultaneous tick
        drive(1, 0, G, R); cycle();
        for (int i = 0; i < 10; i++) begin drive(0, 1, G, R); cycle(); end
        chk("pre_rst_main", bus.cnt_main, 5);
        drive(1, 1, G, R); cycle();
        chk("rst_mid_main", bus.cnt_main, 15);
        chk("rst_mid_aux", bus.cnt_aux, 18);
        chk("rst_mid_an", bus.an, 4'b0111);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [2:0] lm, la;
            lm = bus.light_main; la = bus.light_auxiliary;
            if ($urandom_range(0, 9) == 0)  lm = 3'b001 << $urandom_range(0, 2);
            if ($urandom_range(0, 39) == 0) lm = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)  la = 3'b001 << $urandom_range(0, 2);
            if ($urandom_range(0, 39) == 0) la = 3'($urandom_range(0, 7));
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, lm, la);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
